// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arb_pkg;

    // Sequencer states: accept, strobe the datapath, wait its latency, return result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Datapath op-select encoding.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Width of a down-counter that must hold lat-1; never narrower than one bit.
    function automatic int cnt_width(input int lat);
        return (lat <= 1) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational two-way round-robin: a lone requester always wins, and on
// contention the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    // Grant decode from the request pair and the previous winner.
    always_comb begin
        // NOTE: outputs get a default before the case so every path assigns them and no latch is inferred.
        gnt    = 2'b00;
        gnt_id = 1'b0;
        case (req)
            2'b01: begin
                gnt    = 2'b01;
                gnt_id = 1'b0;
            end
            2'b10: begin
                gnt    = 2'b10;
                gnt_id = 1'b1;
            end
            2'b11: begin
                if (last) begin
                    gnt    = 2'b01;
                    gnt_id = 1'b0;
                end else begin
                    gnt    = 2'b10;
                    gnt_id = 1'b1;
                end
            end
            default: begin
                gnt    = 2'b00;
                gnt_id = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one add/sub datapath between two requesters. One operation is in
// flight at a time: accept, strobe the datapath, wait its fixed latency,
// then hold the tagged result until the consumer takes it.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int WIDTH   = 7,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r0_op,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic             r1_op,

    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             OP,
    output logic             alu_start,
    input  logic [WIDTH:0]   alu_y,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH:0]   rsp_y,

    output logic             busy
);

    localparam int CNT_W = cnt_width(ALU_LAT);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(ALU_LAT - 1);

    state_t           state;
    logic             last_grant;
    logic [CNT_W-1:0] wait_cnt;

    logic [1:0]       gnt;
    logic             gnt_id;
    logic             idle;
    logic             accept;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic             win_op;

    rr_arb2 u_rr (
        .req    ({r1_valid, r0_valid}),
        .last   (last_grant),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    // Ready is only offered while idle; outside IDLE both requesters are held off.
    assign idle     = (state == IDLE);
    assign r0_ready = idle & gnt[0];
    assign r1_ready = idle & gnt[1];
    assign accept   = r0_ready | r1_ready;
    assign busy     = ~idle;

    // Operands of whichever requester the arbiter picked this cycle.
    assign win_a  = gnt_id ? r1_a  : r0_a;
    assign win_b  = gnt_id ? r1_b  : r0_b;
    assign win_op = gnt_id ? r1_op : r0_op;

    // Sequencer FSM with registered datapath drive and response outputs.
    always_ff @(posedge clk) begin
        // NOTE: all state here is sequential, so it is written only with non-blocking assignments.
        if (reset) begin
            // NOTE: the operand and result registers are reset too, because their values are visible on output ports.
            state      <= IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= '0;
            A          <= '0;
            B          <= '0;
            OP         <= OP_ADD;
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_y      <= '0;
        end else begin
            alu_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        A          <= win_a;
                        B          <= win_b;
                        OP         <= win_op;
                        rsp_id     <= gnt_id;
                        last_grant <= gnt_id;
                        alu_start  <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_y     <= alu_y;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance at ALU_LAT=1 for the
// functional sequence, one at ALU_LAT=4 for latency timing.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int W  = 7;
    localparam int L4 = 4;

    logic clk = 1'b0;
    logic reset;

    // Instance with ALU_LAT = 1
    logic         r0_valid, r1_valid, r0_ready, r1_ready;
    logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
    logic         r0_op, r1_op;
    logic [W-1:0] a1, b1;
    logic         op1, start1;
    logic [W:0]   y1;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [W:0]   rsp_y;

    // Instance with ALU_LAT = 4 (requester 1 unused)
    logic         q_valid, q_ready, q_r1_ready;
    logic [W-1:0] q_a, q_b;
    logic         q_op;
    logic [W-1:0] a4, b4;
    logic         op4, start4;
    logic [W:0]   y4;
    logic         q_rsp_valid, q_rsp_ready, q_rsp_id, q_busy;
    logic [W:0]   q_rsp_y;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .ALU_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .A(a1), .B(b1), .OP(op1), .alu_start(start1), .alu_y(y1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
        .busy(busy)
    );

    alu_arbiter #(.WIDTH(W), .ALU_LAT(L4)) dut4 (
        .clk(clk), .reset(reset),
        .r0_valid(q_valid), .r0_ready(q_ready), .r0_a(q_a), .r0_b(q_b), .r0_op(q_op),
        .r1_valid(1'b0), .r1_ready(q_r1_ready), .r1_a(7'd0), .r1_b(7'd0), .r1_op(1'b0),
        .A(a4), .B(b4), .OP(op4), .alu_start(start4), .alu_y(y4),
        .rsp_valid(q_rsp_valid), .rsp_ready(q_rsp_ready), .rsp_id(q_rsp_id), .rsp_y(q_rsp_y),
        .busy(q_busy)
    );

    // Datapath model: result appears ALU_LAT cycles after the start strobe, valid for one cycle.
    function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        return (op == OP_SUB) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    endfunction

    logic [W+1:0] pipe1;
    logic [W+1:0] pipe4 [L4];

    always @(posedge clk) begin
        pipe1 <= {start1, alu_f(a1, b1, op1)};
        pipe4[0] <= {start4, alu_f(a4, b4, op4)};
        for (int i = 1; i < L4; i++) pipe4[i] <= pipe4[i-1];
    end

    assign y1 = pipe1[W+1]       ? pipe1[W:0]       : '0;
    assign y4 = pipe4[L4-1][W+1] ? pipe4[L4-1][W:0] : '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_A"},         32'(a1), 32'd0);
        check({tag, "_B"},         32'(b1), 32'd0);
        check({tag, "_OP"},        32'(op1), 32'd0);
        check({tag, "_alu_start"}, 32'(start1), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_id"},    32'(rsp_id), 32'd0);
        check({tag, "_rsp_y"},     32'(rsp_y), 32'd0);
        check({tag, "_busy"},      32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        r0_valid = 0; r1_valid = 0;
        r0_a = 0; r0_b = 0; r0_op = OP_ADD;
        r1_a = 0; r1_b = 0; r1_op = OP_ADD;
        rsp_ready = 0;
        q_valid = 0; q_a = 0; q_b = 0; q_op = OP_ADD; q_rsp_ready = 1'b1;

        // Reset state
        step(); step();
        check_reset_values("rst");
        check("rst_r0_ready", 32'(r0_ready), 32'd0);
        reset = 1'b0;

        // Single add 5+3 on requester 0
        r0_valid = 1; r0_a = 7'd5; r0_b = 7'd3; r0_op = OP_ADD; rsp_ready = 1;
        settle();
        check("t1_r0_ready_c0", 32'(r0_ready), 32'd1);
        check("t1_r1_ready_c0", 32'(r1_ready), 32'd0);
        step(); r0_valid = 0; settle();
        check("t1_start_c1", 32'(start1), 32'd1);
        check("t1_A", 32'(a1), 32'd5);
        check("t1_B", 32'(b1), 32'd3);
        check("t1_OP", 32'(op1), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_r0_ready_c1", 32'(r0_ready), 32'd0);
        step();
        check("t1_start_c2", 32'(start1), 32'd0);
        check("t1_rsp_valid_c2", 32'(rsp_valid), 32'd0);
        step();
        check("t1_rsp_valid_c3", 32'(rsp_valid), 32'd1);
        check("t1_rsp_id", 32'(rsp_id), 32'd0);
        check("t1_rsp_y", 32'(rsp_y), 32'd8);
        step();
        check("t1_rsp_valid_c4", 32'(rsp_valid), 32'd0);
        check("t1_busy_c4", 32'(busy), 32'd0);
        check("t1_A_held", 32'(a1), 32'd5);

        // Contention after a fresh reset: r0 first, then alternate
        reset = 1; step(); reset = 0;
        r0_valid = 1; r0_a = 7'd100; r0_b = 7'd50; r0_op = OP_SUB;
        r1_valid = 1; r1_a = 7'd127; r1_b = 7'd1;  r1_op = OP_ADD;
        settle();
        check("t2_g0_r0_ready", 32'(r0_ready), 32'd1);
        check("t2_g0_r1_ready", 32'(r1_ready), 32'd0);
        step();
        check("t2_g0_A", 32'(a1), 32'd100);
        check("t2_g0_B", 32'(b1), 32'd50);
        check("t2_g0_OP", 32'(op1), 32'd1);
        check("t2_issue_r0_ready", 32'(r0_ready), 32'd0);
        check("t2_issue_r1_ready", 32'(r1_ready), 32'd0);
        step(); step();
        check("t2_rsp0_valid", 32'(rsp_valid), 32'd1);
        check("t2_rsp0_y", 32'(rsp_y), 32'd50);
        check("t2_rsp0_id", 32'(rsp_id), 32'd0);
        step();
        check("t2_g1_r1_ready", 32'(r1_ready), 32'd1);
        check("t2_g1_r0_ready", 32'(r0_ready), 32'd0);
        step();
        check("t2_g1_A", 32'(a1), 32'd127);
        check("t2_g1_B", 32'(b1), 32'd1);
        step(); step();
        check("t2_rsp1_y", 32'(rsp_y), 32'h80);
        check("t2_rsp1_id", 32'(rsp_id), 32'd1);
        check("t2_rsp1_carry", 32'(rsp_y[W]), 32'd1);
        step();
        check("t2_g2_r0_ready", 32'(r0_ready), 32'd1);
        check("t2_g2_r1_ready", 32'(r1_ready), 32'd0);
        step(); r0_valid = 0; r1_valid = 0;
        check("t2_g2_A", 32'(a1), 32'd100);
        step(); step();
        check("t2_rsp2_y", 32'(rsp_y), 32'd50);
        check("t2_rsp2_id", 32'(rsp_id), 32'd0);
        step();

        // Subtract with borrow: 3 - 5
        r0_valid = 1; r0_a = 7'd3; r0_b = 7'd5; r0_op = OP_SUB;
        settle();
        check("t3_r0_ready", 32'(r0_ready), 32'd1);
        step(); r0_valid = 0;
        step(); step();
        check("t3_rsp_y", 32'(rsp_y), 32'hFE);
        check("t3_borrow", 32'(rsp_y[W]), 32'd1);
        step();

        // Consumer stall in RESP for 10 cycles
        r1_valid = 1; r1_a = 7'd10; r1_b = 7'd20; r1_op = OP_ADD; rsp_ready = 0;
        settle();
        check("t4_r1_ready", 32'(r1_ready), 32'd1);
        step(); r1_valid = 0;
        step(); step();
        r0_valid = 1; r0_a = 7'd1; r0_b = 7'd2; r0_op = OP_ADD;
        r1_valid = 1;
        settle();
        for (int i = 0; i < 10; i++) begin
            check("t4_stall_valid", 32'(rsp_valid), 32'd1);
            check("t4_stall_y", 32'(rsp_y), 32'd30);
            check("t4_stall_id", 32'(rsp_id), 32'd1);
            check("t4_stall_r0_ready", 32'(r0_ready), 32'd0);
            check("t4_stall_r1_ready", 32'(r1_ready), 32'd0);
            step();
        end
        rsp_ready = 1;
        settle();
        check("t4_release_valid", 32'(rsp_valid), 32'd1);
        check("t4_release_r0_ready", 32'(r0_ready), 32'd0);
        step();
        check("t4_next_r0_ready", 32'(r0_ready), 32'd1);
        check("t4_next_r1_ready", 32'(r1_ready), 32'd0);
        check("t4_next_rsp_valid", 32'(rsp_valid), 32'd0);
        step(); r0_valid = 0; r1_valid = 0;
        check("t4_next_A", 32'(a1), 32'd1);
        check("t4_next_B", 32'(b1), 32'd2);
        step(); step();
        check("t4_next_rsp_y", 32'(rsp_y), 32'd3);
        check("t4_next_rsp_id", 32'(rsp_id), 32'd0);
        step();

        // Reset while waiting on the datapath
        r0_valid = 1; r0_a = 7'd20; r0_b = 7'd7; r0_op = OP_ADD;
        settle();
        check("t5_r0_ready", 32'(r0_ready), 32'd1);
        step(); r0_valid = 0;
        step();
        check("t5_in_wait_busy", 32'(busy), 32'd1);
        reset = 1;
        step();
        check_reset_values("t5_rst");
        reset = 0;
        r0_valid = 1; r1_valid = 1; r1_a = 7'd10; r1_b = 7'd20; r1_op = OP_ADD;
        settle();
        check("t5_r0_first", 32'(r0_ready), 32'd1);
        check("t5_r1_not", 32'(r1_ready), 32'd0);
        check("t5_no_rsp", 32'(rsp_valid), 32'd0);
        step(); r0_valid = 0; r1_valid = 0;
        step(); step();
        check("t5_rsp_y", 32'(rsp_y), 32'd27);
        check("t5_rsp_id", 32'(rsp_id), 32'd0);
        step();

        // ALU_LAT = 4 instance: 9 + 9
        q_valid = 1; q_a = 7'd9; q_b = 7'd9; q_op = OP_ADD;
        settle();
        check("t6_q_ready", 32'(q_ready), 32'd1);
        step(); q_valid = 0;
        check("t6_start_c1", 32'(start4), 32'd1);
        check("t6_A", 32'(a4), 32'd9);
        for (int i = 2; i <= 5; i++) begin
            step();
            check("t6_start_low", 32'(start4), 32'd0);
            check("t6_rsp_not_yet", 32'(q_rsp_valid), 32'd0);
        end
        step();
        check("t6_rsp_valid_c6", 32'(q_rsp_valid), 32'd1);
        check("t6_rsp_y", 32'(q_rsp_y), 32'd18);
        check("t6_rsp_id", 32'(q_rsp_id), 32'd0);
        step();
        check("t6_rsp_done", 32'(q_rsp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the 7-bit add/sub datapath (operands A, B, op-select OP) between two requesters. It accepts one operation at a time over a valid/ready handshake. It drives A/B/OP plus a start strobe to the datapath and waits the datapath's fixed latency. It then returns the WIDTH+1-bit result, tagged with the requester id, over a second valid/ready handshake. It sits between the operand-generating controllers and the shared ALU.

## Interface
- WIDTH, 7: operand width.
- ALU_LAT, 1: datapath latency in cycles, ≥1.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- r0_valid / r1_valid  in  1  requester 0/1 has an operation.
- r0_ready / r1_ready  out  1  operation accepted this cycle.
- r0_a, r0_b / r1_a, r1_b  in  WIDTH  operands.
- r0_op / r1_op  in  1  0 = add, 1 = subtract.
- A, B  out  WIDTH  operands to datapath.
- OP  out  1  op-select to datapath.
- alu_start  out  1  one-cycle start strobe.
- alu_y  in  WIDTH+1  datapath result; MSB is carry (add) or borrow (sub).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_id  out  1  requester that owns the result.
- rsp_y  out  WIDTH+1  captured result.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - Compute grant from r0_valid, r1_valid and the last_grant register.
  - Only one valid: that requester wins, whatever last_grant holds.
  - Both valid: the requester ≠ last_grant wins.
  - r<grant>_ready = 1 combinationally; the other ready = 0. Both ready = 0 when neither is valid.
  - On valid&ready: register the winner's a/b/op into A/B/OP, set rsp_id = winner, set last_grant = winner, go to ISSUE.
- **ISSUE**: alu_start = 1 for exactly this cycle; A/B/OP held. Next state WAIT; load wait counter with ALU_LAT-1.
- **WAIT**
  - Lasts exactly ALU_LAT cycles; counter decrements each cycle.
  - In the cycle the counter is 0, capture alu_y into rsp_y at the closing edge, then go to RESP.
- **RESP**
  - rsp_valid = 1; rsp_id, rsp_y, A, B and OP are stable.
  - Leave to IDLE on the cycle rsp_ready = 1.
  - Hold indefinitely while rsp_ready = 0.
- Outside IDLE, r0_ready = r1_ready = 0.
- A/B/OP keep their last values in IDLE until the next accept.
- Requester rule: a requester holds valid and its operands until ready. The arbiter still tolerates valid dropping before acceptance; it then simply does not grant.

## Timing
- Reset values (on every reset edge, including mid-operation):
  - state = IDLE, last_grant = 1 (requester 0 wins the first contention).
  - A = B = 0, OP = 0, alu_start = 0, rsp_valid = 0, rsp_id = 0, rsp_y = 0, busy = 0.
  - Any in-flight operation is dropped with no response.
- Accept at edge t → alu_start high in cycle t+1 → rsp_valid high from cycle t+2+ALU_LAT.
- Minimum spacing between accepts is ALU_LAT+3 cycles, when rsp_ready is held high.
- The new accept can happen in the IDLE cycle right after the RESP handshake cycle; there is no bubble beyond IDLE.
- rsp_ready high before RESP has no effect.
- rsp_ready low in RESP stalls the block: neither requester gets ready.
- Results are not masked: the full WIDTH+1 bits of alu_y are passed through.

## Structure
- Package alu_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - OP_ADD = 1'b0, OP_SUB = 1'b1;
  - the ALU_LAT counter width derivation.
- One sub-module, rr_arb2: combinational 2-way round-robin.
  - Inputs: req[1:0], last.
  - Outputs: gnt[1:0] (one-hot or zero), gnt_id.
  - last_grant stays in the parent FSM.

## Test plan
- Reset, then r0_valid = 1 with a = 7'd5, b = 7'd3, op = add, ALU_LAT = 1, rsp_ready = 1:
  - r0_ready in cycle 0; alu_start in cycle 1;
  - rsp_valid in cycle 3 with rsp_id = 0 and rsp_y = 8'd8.
- Both valid every cycle, r0 = (100, 50, sub), r1 = (127, 1, add):
  - grants alternate r0, r1, r0;
  - responses are 8'd50 (id 0) and 8'd128 (id 1, carry set).
- Sub with borrow, a = 3, b = 5:
  - rsp_y = 9'h1FE truncated to 8 bits = 8'hFE, MSB = 1.
- rsp_ready held low 10 cycles in RESP:
  - rsp_valid, rsp_y, rsp_id stable;
  - r0_ready = r1_ready = 0 despite both valid;
  - release completes the handshake and the next grant occurs the following cycle.
- Assert reset during WAIT:
  - next cycle all outputs are at reset values with no response;
  - with both requesters valid afterwards, r0 is granted first.
- ALU_LAT = 4:
  - alu_start is a single-cycle pulse;
  - rsp_valid occurs exactly 6 cycles after the accept edge.
